ldr_unit: RTL and testbench

- Load-data stage directly upstream of the 16-entry register bank.
- Accepts an LDR command (destination register index + address) over a valid/ready handshake.
- Issues one read on a req/ack memory port and captures the returned word.
- Drives the register bank's one-hot 16-bit write enable and 32-bit load-data bus for exactly one cycle per completed load.

---
 rtl/ldr_unit.sv | 119 +++++++++++
 tb/tb_ldr_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldr_unit.sv
// ldr_unit: load-data stage feeding a 16-entry register bank.
//
// Accepts an LDR command (destination index + address) on a valid/ready
// handshake, issues a single read on a req/ack memory port, and presents the
// returned word on ldr_data with a one-cycle one-hot write enable.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_rd = destination, cmd_addr = address
//   mem_req/addr      read request, held with a stable address until mem_ack
//   mem_ack/rdata     read data strobe and data
//   enable            one-hot register write enable, zero when not writing
//   ldr_data          load data (holds last value; only enable qualifies it)
//   busy              a load is in flight
//   err               one-cycle abort pulse (timeout build only, else 0)
//
// Optional build macro: LDR_TIMEOUT_EN enables the REQ-state timeout
// (TIMEOUT cycles without mem_ack abort the load with an err pulse).
module ldr_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       enable,
  output logic [DATA_W-1:0] ldr_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] rd;

`ifdef LDR_TIMEOUT_EN
  // Abort happens on the edge where the no-ack count would reach TIMEOUT,
  // so mem_req is high for exactly TIMEOUT cycles before err pulses.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = (state == IDLE) || (state == WB);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      enable   <= '0;
      ldr_data <= '0;
`ifdef LDR_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      enable <= '0;
`ifdef LDR_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE, WB: begin
          if (cmd_valid) begin
            rd       <= cmd_rd;
            mem_addr <= cmd_addr;
            mem_req  <= 1'b1;
            state    <= REQ;
`ifdef LDR_TIMEOUT_EN
            cnt      <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (mem_ack) begin
            ldr_data <= mem_rdata;
            enable   <= 16'h0001 << rd;
            mem_req  <= 1'b0;
            state    <= WB;
          end
`ifdef LDR_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            mem_req <= 1'b0;
            err_q   <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldr_unit.sv
// Self-checking bench for ldr_unit: directed scenarios plus a randomized
// run scored against a command-queue reference model.
module tb_ldr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_rd;
  logic [31:0] cmd_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] enable;
  logic [31:0] ldr_data;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ldr_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .enable(enable), .ldr_data(ldr_data),
    .busy(busy), .err(err)
  );

  // Memory contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] r);
    logic [15:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    cmd_rd    = '0;
    cmd_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Zero-wait load, ending back in IDLE.
  task automatic do_load(input logic [3:0] r, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_rd = r; cmd_addr = a;
    step();
    cmd_valid = 1'b0; mem_ack = 1'b1; mem_rdata = d;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({cmd_ready, mem_req, mem_addr, enable, ldr_data, busy, err} !==
        {1'b1, 1'b0, 32'h0, 16'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b req=%b addr=%h en=%h data=%h busy=%b err=%b, expected 1 0 0 0 0 0 0",
               cmd_ready, mem_req, mem_addr, enable, ldr_data, busy, err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    cmd_valid = 1'b1; cmd_rd = 4'd3; cmd_addr = 32'h0000_0040;
    step();
    tests++;
    if ({mem_req, mem_addr, cmd_ready, enable, busy} !== {1'b1, 32'h40, 1'b0, 16'h0, 1'b1}) begin
      fails++;
      $display("FAIL basic_req: got req=%b addr=%h rdy=%b en=%h busy=%b, expected 1 00000040 0 0000 1",
               mem_req, mem_addr, cmd_ready, enable, busy);
    end
    cmd_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    tests++;
    if ({enable, ldr_data, mem_req} !== {16'h0008, 32'hDEAD_BEEF, 1'b0}) begin
      fails++;
      $display("FAIL basic_wb: got en=%h data=%h req=%b, expected 0008 deadbeef 0", enable, ldr_data, mem_req);
    end
    step();
    tests++;
    if ({enable, busy, ldr_data} !== {16'h0, 1'b0, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL basic_after: got en=%h busy=%b data=%h, expected 0000 0 deadbeef", enable, busy, ldr_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_valid = 1'b1; cmd_rd = 4'd0; cmd_addr = 32'h0000_0100;
    step();
    // The held command changes to the next one while the first is in REQ.
    cmd_rd = 4'd15; cmd_addr = 32'h0000_0200; mem_ack = 1'b1; mem_rdata = 32'h1;
    step();
    mem_ack = 1'b0;
    tests++;
    if ({enable, ldr_data, cmd_ready} !== {16'h0001, 32'h1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_first: got en=%h data=%h rdy=%b, expected 0001 00000001 1", enable, ldr_data, cmd_ready);
    end
    step();
    tests++;
    if ({enable, mem_req, mem_addr} !== {16'h0, 1'b1, 32'h200}) begin
      fails++;
      $display("FAIL b2b_gap: got en=%h req=%b addr=%h, expected 0000 1 00000200", enable, mem_req, mem_addr);
    end
    cmd_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h2;
    step();
    mem_ack = 1'b0;
    tests++;
    if ({enable, ldr_data} !== {16'h8000, 32'h2}) begin
      fails++;
      $display("FAIL b2b_second: got en=%h data=%h, expected 8000 00000002", enable, ldr_data);
    end
    step();
    tests++;
    if ({enable, busy} !== {16'h0, 1'b0}) begin
      fails++;
      $display("FAIL b2b_after: got en=%h busy=%b, expected 0000 0", enable, busy);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a, d;
    do_reset();
    a = $urandom; d = $urandom;
    cmd_valid = 1'b1; cmd_rd = 4'd9; cmd_addr = a;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if ({mem_req, mem_addr, cmd_ready, enable} !== {1'b1, a, 1'b0, 16'h0}) begin
        fails++;
        $display("FAIL wait_req%0d: got req=%b addr=%h rdy=%b en=%h, expected 1 %h 0 0000",
                 i, mem_req, mem_addr, cmd_ready, enable, a);
      end
      if (i == 5) begin
        mem_ack = 1'b1; mem_rdata = d;
      end
      step();
    end
    mem_ack = 1'b0;
    tests++;
    if ({enable, ldr_data, mem_req} !== {16'h0200, d, 1'b0}) begin
      fails++;
      $display("FAIL wait_wb: got en=%h data=%h req=%b, expected 0200 %h 0", enable, ldr_data, mem_req, d);
    end
    step();
    tests++;
    if (enable !== 16'h0) begin
      fails++;
      $display("FAIL wait_after: got en=%h, expected 0000", enable);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    do_load(4'd7, 32'h10, 32'hAAAA_5555);
    cmd_valid = 1'b1; cmd_rd = 4'd2; cmd_addr = 32'h20;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tests++;
    if ({mem_req, enable, ldr_data, busy} !== {1'b0, 16'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid: got req=%b en=%h data=%h busy=%b, expected 0 0000 0 0", mem_req, enable, ldr_data, busy);
    end
    step();
    mem_ack = 1'b0;
    tests++;
    if ({mem_req, enable, ldr_data, busy} !== {1'b0, 16'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid_late_ack: got req=%b en=%h data=%h busy=%b, expected 0 0000 0 0",
               mem_req, enable, ldr_data, busy);
    end
    // Reset and ack in the same REQ cycle: reset wins.
    do_load(4'd7, 32'h10, 32'hAAAA_5555);
    cmd_valid = 1'b1; cmd_rd = 4'd4; cmd_addr = 32'h30;
    step();
    cmd_valid = 1'b0; rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    rst = 1'b0; mem_ack = 1'b0;
    tests++;
    if ({mem_req, enable, ldr_data, busy} !== {1'b0, 16'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL rst_with_ack: got req=%b en=%h data=%h busy=%b, expected 0 0000 0 0",
               mem_req, enable, ldr_data, busy);
    end
  endtask

  task automatic test_stray_ack();
    do_reset();
    do_load(4'd1, 32'h44, 32'hCAFE_0001);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    step();
    tests++;
    if ({enable, ldr_data, busy, mem_req} !== {16'h0, 32'hCAFE_0001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL stray_ack: got en=%h data=%h busy=%b req=%b, expected 0000 cafe0001 0 0",
               enable, ldr_data, busy, mem_req);
    end
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef LDR_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_rd = 4'd5; cmd_addr = 32'h50;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mem_req, err, enable} !== {1'b1, 1'b0, 16'h0}) begin
        fails++;
        $display("FAIL timeout_wait%0d: got req=%b err=%b en=%h, expected 1 0 0000", i, mem_req, err, enable);
      end
      step();
    end
    tests++;
    if ({mem_req, err, busy, enable, cmd_ready} !== {1'b0, 1'b1, 1'b0, 16'h0, 1'b1}) begin
      fails++;
      $display("FAIL timeout_abort: got req=%b err=%b busy=%b en=%h rdy=%b, expected 0 1 0 0000 1",
               mem_req, err, busy, enable, cmd_ready);
    end
    step();
    tests++;
    if ({err, enable} !== {1'b0, 16'h0}) begin
      fails++;
      $display("FAIL timeout_after: got err=%b en=%h, expected 0 0000", err, enable);
    end
    // Ack on the limit cycle completes the load.
    cmd_valid = 1'b1; cmd_rd = 4'd6; cmd_addr = 32'h60;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0;
    tests++;
    if ({enable, ldr_data, err} !== {16'h0040, 32'h0BAD_F00D, 1'b0}) begin
      fails++;
      $display("FAIL timeout_ack_wins: got en=%h data=%h err=%b, expected 0040 0badf00d 0", enable, ldr_data, err);
    end
`else
    begin
      int bad;
      bad = 0;
      cmd_valid = 1'b1; cmd_rd = 4'd5; cmd_addr = 32'h50;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 120; i++) begin
        if ({mem_req, err, enable} !== {1'b1, 1'b0, 16'h0}) bad++;
        step();
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL no_timeout: %0d of 120 cycles not holding req=1 err=0 en=0, expected 0", bad);
      end
    end
`endif
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0]  q_rd[$];
    logic [31:0] q_addr[$];
    logic [3:0]  r;
    logic [31:0] a;
    int          issued;
    bit          acc;
    bit          done;
    localparam int N = 40;
    do_reset();
    issued = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) begin
        q_rd.push_back(cmd_rd);
        q_addr.push_back(cmd_addr);
        issued++;
      end
      if (enable !== 16'h0) begin
        tests++;
        if (q_rd.size() == 0) begin
          fails++;
          $display("FAIL rand_write: got en=%h with no load outstanding, expected 0000", enable);
        end else begin
          r = q_rd.pop_front();
          a = q_addr.pop_front();
          if ({enable, ldr_data} !== {onehot(r), mem_fn(a)}) begin
            fails++;
            $display("FAIL rand_write: got en=%h data=%h, expected %h %h", enable, ldr_data, onehot(r), mem_fn(a));
          end
        end
      end
      if (mem_req) begin
        tests++;
        if (q_addr.size() == 0 || mem_addr !== q_addr[$]) begin
          fails++;
          $display("FAIL rand_addr: got addr=%h, expected %h (outstanding=%0d)", mem_addr,
                   (q_addr.size() == 0) ? 32'h0 : q_addr[$], q_addr.size());
        end
      end
      if (acc || !cmd_valid) begin
        if (issued < N && ($urandom % 3) != 0) begin
          cmd_valid = 1'b1;
          cmd_rd    = 4'($urandom);
          cmd_addr  = $urandom;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (mem_req) begin
        mem_ack   = (($urandom % 3) == 0);
        mem_rdata = mem_ack ? mem_fn(mem_addr) : $urandom;
      end else begin
        mem_ack   = (($urandom % 4) == 0);
        mem_rdata = $urandom;
      end
      done = (issued == N) && !cmd_valid && (q_rd.size() == 0) && !busy;
    end
    idle_inputs();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL rand_complete: issued %0d with %0d outstanding within cycle budget, expected %0d and 0",
               issued, q_rd.size(), N);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_load();
    test_stray_ack();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
